// File: rtl/fft_output_unloader.sv
`default_nettype none
// ============================================================================
// Module   : fft_output_unloader
// Purpose  : Streams the N complex results of a finished transform out of the
//            FFT working memory, LANES samples per beat, with optional
//            bit-reversed storage addressing, configurable RAM read latency
//            and ready/valid backpressure without sample loss.
// Ports    : clk, reset (async, active high)
//            start, bitrev_mode           - unload request / addressing mode
//            rd_en, rd_addr, rd_data      - RAM read ports (one per lane)
//            out_samp, out_index,
//            out_valid, out_ready,
//            out_last                     - output beat stream
//            busy, done                   - unload status
// Revision : 1.0 - initial release
// ============================================================================
module fft_output_unloader #(
  parameter int N             = 32,
  parameter int WORD_SIZE     = 16,
  parameter int LANES         = 2,
  parameter int RD_LATENCY    = 1,
  parameter int ADDRESS_WIDTH = $clog2(N)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           bitrev_mode,
  output logic                           rd_en,
  output logic [LANES*ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [LANES*2*WORD_SIZE-1:0]   rd_data,
  output logic [LANES*2*WORD_SIZE-1:0]   out_samp,
  output logic [ADDRESS_WIDTH-1:0]       out_index,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done
);

  localparam int c_AW    = ADDRESS_WIDTH;
  localparam int c_SW    = LANES * 2 * WORD_SIZE;
  localparam int c_DEPTH = RD_LATENCY + 2;
  localparam int c_PW    = $clog2(c_DEPTH);
  localparam int c_NW    = $clog2(c_DEPTH + 1);
  localparam int c_CW    = $clog2(2 * c_DEPTH + 2) + 1;

  localparam logic [c_AW-1:0] c_STEP     = c_AW'(LANES);
  localparam logic [c_AW-1:0] c_LAST_IDX = c_AW'(N - LANES);
  localparam logic [c_PW-1:0] c_PTR_MAX  = c_PW'(c_DEPTH - 1);
  localparam logic [c_CW-1:0] c_DEPTH_C  = c_CW'(c_DEPTH);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  function automatic logic [c_AW-1:0] f_bitrev(input logic [c_AW-1:0] a);
    logic [c_AW-1:0] rev;
    for (int i = 0; i < c_AW; i++) rev[i] = a[c_AW-1-i];
    return rev;
  endfunction

  logic [1:0]            r_state;
  logic                  r_bitrev;
  logic [c_AW-1:0]       r_issue_idx;
  logic                  r_busy;
  logic                  r_done;
  logic [LANES*c_AW-1:0] r_rd_addr;
  // Read-return delay line: stage 0 is the registered rd_en itself, stage
  // RD_LATENCY is the cycle in which rd_data carries that beat.
  logic                  r_vp [0:RD_LATENCY];
  logic [c_AW-1:0]       r_ip [0:RD_LATENCY];

  logic [c_SW-1:0]       r_mem_samp [0:c_DEPTH-1];
  logic [c_AW-1:0]       r_mem_idx  [0:c_DEPTH-1];
  logic [c_PW-1:0]       r_wr_ptr;
  logic [c_PW-1:0]       r_rd_ptr;
  logic [c_NW-1:0]       r_count;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_credit_ok;
  logic                  w_mode;
  logic [c_AW-1:0]       w_base;
  logic [c_CW-1:0]       w_inflight;
  logic [LANES*c_AW-1:0] w_addr;

  assign w_push = r_vp[RD_LATENCY];
  assign w_pop  = out_valid && out_ready;

  always_comb begin
    w_inflight = '0;
    for (int j = 0; j <= RD_LATENCY; j++) w_inflight = w_inflight + c_CW'(r_vp[j]);
  end

  // Every issued beat owns a FIFO slot from issue until it is popped. A slot
  // being popped this cycle is free again, which keeps one beat per cycle
  // flowing when the consumer never stalls.
  assign w_credit_ok = (w_inflight + c_CW'(r_count)) < (c_DEPTH_C + c_CW'(w_pop));

  // The first beat is issued in the same cycle the start is accepted.
  assign w_issue = ((r_state == c_IDLE) && start) || ((r_state == c_RUN) && w_credit_ok);
  assign w_base  = (r_state == c_IDLE) ? '0 : r_issue_idx;
  assign w_mode  = (r_state == c_IDLE) ? bitrev_mode : r_bitrev;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [c_AW-1:0] w_lin;
    assign w_lin = w_base + c_AW'(k);
    assign w_addr[k*c_AW +: c_AW] = w_mode ? f_bitrev(w_lin) : w_lin;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= c_IDLE;
      r_bitrev    <= 1'b0;
      r_issue_idx <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_addr   <= '0;
      for (int j = 0; j <= RD_LATENCY; j++) begin
        r_vp[j] <= 1'b0;
        r_ip[j] <= '0;
      end
    end else begin
      r_done  <= 1'b0;
      r_vp[0] <= w_issue;
      if (w_issue) begin
        r_ip[0]   <= w_base;
        r_rd_addr <= w_addr;
      end
      for (int j = 1; j <= RD_LATENCY; j++) begin
        r_vp[j] <= r_vp[j-1];
        r_ip[j] <= r_ip[j-1];
      end
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_state     <= c_RUN;
            r_bitrev    <= bitrev_mode;
            r_issue_idx <= c_STEP;
            r_busy      <= 1'b1;
          end
        end
        c_RUN: begin
          if (w_issue) begin
            if (r_issue_idx == c_LAST_IDX) r_state <= c_DRAIN;
            else                           r_issue_idx <= r_issue_idx + c_STEP;
          end
        end
        c_DRAIN: begin
          if (w_pop && out_last) begin
            r_state <= c_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_samp[r_wr_ptr] <= rd_data;
      r_mem_idx[r_wr_ptr]  <= r_ip[RD_LATENCY];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == c_PTR_MAX) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_PTR_MAX) ? '0 : r_rd_ptr + 1'b1;
      r_count <= r_count + c_NW'(w_push) - c_NW'(w_pop);
    end
  end

  // Head fields are gated by valid so every output reads zero while empty,
  // including immediately on reset.
  assign out_valid = (r_count != '0);
  assign out_samp  = out_valid ? r_mem_samp[r_rd_ptr] : '0;
  assign out_index = out_valid ? r_mem_idx[r_rd_ptr]  : '0;
  assign out_last  = out_valid && (out_index == c_LAST_IDX);
  assign rd_en     = r_vp[0];
  assign rd_addr   = r_rd_addr;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire
